// File: rtl/axi_mem_arb2.sv
// axi_mem_arb2: two-master AXI4 arbiter in front of a single AXI block memory.
// Read and write directions are arbitrated independently with round-robin grants.
// The grant is held for a whole burst, and each direction has one transaction in flight.
// Ports:
//   s_aclk, s_areset          clock and synchronous active-high reset
//   s0_axi_*, s1_axi_*        AXI4 slave ports facing the two requesters
//   m_axi_*                   AXI4 master port facing the memory
module axi_mem_arb2 #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_ID_WIDTH  = 1
) (
    input  logic                     s_aclk,
    input  logic                     s_areset,
    // port 0
    input  logic [G_ID_WIDTH-1:0]    s0_axi_awid,
    input  logic [31:0]              s0_axi_awaddr,
    input  logic [7:0]               s0_axi_awlen,
    input  logic [2:0]               s0_axi_awsize,
    input  logic [1:0]               s0_axi_awburst,
    input  logic                     s0_axi_awvalid,
    output logic                     s0_axi_awready,
    input  logic [G_DATAWIDTH-1:0]   s0_axi_wdata,
    input  logic [G_DATAWIDTH/8-1:0] s0_axi_wstrb,
    input  logic                     s0_axi_wlast,
    input  logic                     s0_axi_wvalid,
    output logic                     s0_axi_wready,
    output logic [G_ID_WIDTH-1:0]    s0_axi_bid,
    output logic [1:0]               s0_axi_bresp,
    output logic                     s0_axi_bvalid,
    input  logic                     s0_axi_bready,
    input  logic [G_ID_WIDTH-1:0]    s0_axi_arid,
    input  logic [31:0]              s0_axi_araddr,
    input  logic [7:0]               s0_axi_arlen,
    input  logic [2:0]               s0_axi_arsize,
    input  logic [1:0]               s0_axi_arburst,
    input  logic                     s0_axi_arvalid,
    output logic                     s0_axi_arready,
    output logic [G_ID_WIDTH-1:0]    s0_axi_rid,
    output logic [G_DATAWIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]               s0_axi_rresp,
    output logic                     s0_axi_rlast,
    output logic                     s0_axi_rvalid,
    input  logic                     s0_axi_rready,
    // port 1
    input  logic [G_ID_WIDTH-1:0]    s1_axi_awid,
    input  logic [31:0]              s1_axi_awaddr,
    input  logic [7:0]               s1_axi_awlen,
    input  logic [2:0]               s1_axi_awsize,
    input  logic [1:0]               s1_axi_awburst,
    input  logic                     s1_axi_awvalid,
    output logic                     s1_axi_awready,
    input  logic [G_DATAWIDTH-1:0]   s1_axi_wdata,
    input  logic [G_DATAWIDTH/8-1:0] s1_axi_wstrb,
    input  logic                     s1_axi_wlast,
    input  logic                     s1_axi_wvalid,
    output logic                     s1_axi_wready,
    output logic [G_ID_WIDTH-1:0]    s1_axi_bid,
    output logic [1:0]               s1_axi_bresp,
    output logic                     s1_axi_bvalid,
    input  logic                     s1_axi_bready,
    input  logic [G_ID_WIDTH-1:0]    s1_axi_arid,
    input  logic [31:0]              s1_axi_araddr,
    input  logic [7:0]               s1_axi_arlen,
    input  logic [2:0]               s1_axi_arsize,
    input  logic [1:0]               s1_axi_arburst,
    input  logic                     s1_axi_arvalid,
    output logic                     s1_axi_arready,
    output logic [G_ID_WIDTH-1:0]    s1_axi_rid,
    output logic [G_DATAWIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]               s1_axi_rresp,
    output logic                     s1_axi_rlast,
    output logic                     s1_axi_rvalid,
    input  logic                     s1_axi_rready,
    // memory side
    output logic [G_ID_WIDTH-1:0]    m_axi_awid,
    output logic [31:0]              m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [G_DATAWIDTH-1:0]   m_axi_wdata,
    output logic [G_DATAWIDTH/8-1:0] m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [G_ID_WIDTH-1:0]    m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [G_ID_WIDTH-1:0]    m_axi_arid,
    output logic [31:0]              m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [G_ID_WIDTH-1:0]    m_axi_rid,
    input  logic [G_DATAWIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wstate_t;
    typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_t;

    wstate_t wstate;
    rstate_t rstate;
    logic    wgnt, wptr;
    logic    rgnt, rptr;

    // wptr/rptr hold the last port served; on a tie the other port wins.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            wstate <= WIDLE;
            wgnt   <= 1'b0;
            wptr   <= 1'b0;
        end else begin
            case (wstate)
                WIDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
                    wgnt   <= (s0_axi_awvalid && s1_axi_awvalid) ? ~wptr : s1_axi_awvalid;
                    wstate <= WADDR;
                end
                WADDR: if (m_axi_awvalid && m_axi_awready) wstate <= WDATA;
                WDATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wstate <= WRESP;
                WRESP: if (m_axi_bvalid && m_axi_bready) begin
                    wptr   <= wgnt;
                    wstate <= WIDLE;
                end
                default: wstate <= WIDLE;
            endcase
        end
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            rstate <= RIDLE;
            rgnt   <= 1'b0;
            rptr   <= 1'b0;
        end else begin
            case (rstate)
                RIDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
                    rgnt   <= (s0_axi_arvalid && s1_axi_arvalid) ? ~rptr : s1_axi_arvalid;
                    rstate <= RADDR;
                end
                RADDR: if (m_axi_arvalid && m_axi_arready) rstate <= RDATA;
                RDATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                    rptr   <= rgnt;
                    rstate <= RIDLE;
                end
                default: rstate <= RIDLE;
            endcase
        end
    end

    logic w_addr, w_data, w_resp, r_addr, r_data;
    assign w_addr = (wstate == WADDR);
    assign w_data = (wstate == WDATA);
    assign w_resp = (wstate == WRESP);
    assign r_addr = (rstate == RADDR);
    assign r_data = (rstate == RDATA);

    // write address
    assign m_axi_awid     = wgnt ? s1_axi_awid    : s0_axi_awid;
    assign m_axi_awaddr   = wgnt ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_awlen    = wgnt ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_awsize   = wgnt ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_awburst  = wgnt ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_awvalid  = w_addr & (wgnt ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = w_addr & ~wgnt & m_axi_awready;
    assign s1_axi_awready = w_addr &  wgnt & m_axi_awready;

    // write data: held off until the port's burst reaches the data phase
    assign m_axi_wdata    = wgnt ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb    = wgnt ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wlast    = wgnt ? s1_axi_wlast : s0_axi_wlast;
    assign m_axi_wvalid   = w_data & (wgnt ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready  = w_data & ~wgnt & m_axi_wready;
    assign s1_axi_wready  = w_data &  wgnt & m_axi_wready;

    // write response
    assign s0_axi_bid     = m_axi_bid;
    assign s0_axi_bresp   = m_axi_bresp;
    assign s1_axi_bid     = m_axi_bid;
    assign s1_axi_bresp   = m_axi_bresp;
    assign s0_axi_bvalid  = w_resp & ~wgnt & m_axi_bvalid;
    assign s1_axi_bvalid  = w_resp &  wgnt & m_axi_bvalid;
    assign m_axi_bready   = w_resp & (wgnt ? s1_axi_bready : s0_axi_bready);

    // read address
    assign m_axi_arid     = rgnt ? s1_axi_arid    : s0_axi_arid;
    assign m_axi_araddr   = rgnt ? s1_axi_araddr  : s0_axi_araddr;
    assign m_axi_arlen    = rgnt ? s1_axi_arlen   : s0_axi_arlen;
    assign m_axi_arsize   = rgnt ? s1_axi_arsize  : s0_axi_arsize;
    assign m_axi_arburst  = rgnt ? s1_axi_arburst : s0_axi_arburst;
    assign m_axi_arvalid  = r_addr & (rgnt ? s1_axi_arvalid : s0_axi_arvalid);
    assign s0_axi_arready = r_addr & ~rgnt & m_axi_arready;
    assign s1_axi_arready = r_addr &  rgnt & m_axi_arready;

    // read data
    assign s0_axi_rid     = m_axi_rid;
    assign s0_axi_rdata   = m_axi_rdata;
    assign s0_axi_rresp   = m_axi_rresp;
    assign s0_axi_rlast   = m_axi_rlast;
    assign s1_axi_rid     = m_axi_rid;
    assign s1_axi_rdata   = m_axi_rdata;
    assign s1_axi_rresp   = m_axi_rresp;
    assign s1_axi_rlast   = m_axi_rlast;
    assign s0_axi_rvalid  = r_data & ~rgnt & m_axi_rvalid;
    assign s1_axi_rvalid  = r_data &  rgnt & m_axi_rvalid;
    assign m_axi_rready   = r_data & (rgnt ? s1_axi_rready : s0_axi_rready);

endmodule

// File: tb/tb_axi_mem_arb2.sv
// tb_axi_mem_arb2: scoreboard bench for axi_mem_arb2 with a behavioural AXI memory.
// Expected B/R responses and grant order are queued by stimulus and checked by a monitor.
module tb_axi_mem_arb2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // master-side signals, index = port
    logic [0:0]  s_awid [2];
    logic [31:0] s_awaddr [2];
    logic [7:0]  s_awlen [2];
    logic [2:0]  s_awsize [2];
    logic [1:0]  s_awburst [2];
    logic        s_awvalid [2];
    logic        s_awready [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wstrb [2];
    logic        s_wlast [2];
    logic        s_wvalid [2];
    logic        s_wready [2];
    logic [0:0]  s_bid [2];
    logic [1:0]  s_bresp [2];
    logic        s_bvalid [2];
    logic        s_bready [2];
    logic [0:0]  s_arid [2];
    logic [31:0] s_araddr [2];
    logic [7:0]  s_arlen [2];
    logic [2:0]  s_arsize [2];
    logic [1:0]  s_arburst [2];
    logic        s_arvalid [2];
    logic        s_arready [2];
    logic [0:0]  s_rid [2];
    logic [31:0] s_rdata [2];
    logic [1:0]  s_rresp [2];
    logic        s_rlast [2];
    logic        s_rvalid [2];
    logic        s_rready [2];

    // memory-side signals
    logic [0:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [0:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic [0:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid, m_arready;
    logic [0:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready;

    axi_mem_arb2 dut (
        .s_aclk(clk), .s_areset(rst),
        .s0_axi_awid(s_awid[0]), .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]),
        .s0_axi_awsize(s_awsize[0]), .s0_axi_awburst(s_awburst[0]),
        .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
        .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wlast(s_wlast[0]),
        .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
        .s0_axi_bid(s_bid[0]), .s0_axi_bresp(s_bresp[0]),
        .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]),
        .s0_axi_arid(s_arid[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arlen(s_arlen[0]),
        .s0_axi_arsize(s_arsize[0]), .s0_axi_arburst(s_arburst[0]),
        .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]),
        .s0_axi_rid(s_rid[0]), .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]),
        .s0_axi_rlast(s_rlast[0]), .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
        .s1_axi_awid(s_awid[1]), .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]),
        .s1_axi_awsize(s_awsize[1]), .s1_axi_awburst(s_awburst[1]),
        .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
        .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wlast(s_wlast[1]),
        .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
        .s1_axi_bid(s_bid[1]), .s1_axi_bresp(s_bresp[1]),
        .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]),
        .s1_axi_arid(s_arid[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arlen(s_arlen[1]),
        .s1_axi_arsize(s_arsize[1]), .s1_axi_arburst(s_arburst[1]),
        .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]),
        .s1_axi_rid(s_rid[1]), .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]),
        .s1_axi_rlast(s_rlast[1]), .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst),
        .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    // behavioural memory: word-addressed, INCR bursts, reloads its pattern on reset
    logic [31:0] mem [1024];
    logic [1:0]  ws;
    logic [9:0]  waddr;
    logic [0:0]  wid;
    logic        rs;
    logic [9:0]  raddr;
    logic [7:0]  rlen, rcnt;

    always @(posedge clk) begin
        if (rst) begin
            ws <= 2'd0;
            m_awready <= 1'b0;
            m_wready <= 1'b0;
            m_bvalid <= 1'b0;
            m_bid <= 1'b0;
            m_bresp <= 2'd0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else begin
            case (ws)
                2'd0: begin
                    m_awready <= 1'b1;
                    if (m_awvalid && m_awready) begin
                        waddr <= m_awaddr[11:2];
                        wid <= m_awid;
                        m_awready <= 1'b0;
                        m_wready <= 1'b1;
                        ws <= 2'd1;
                    end
                end
                2'd1: if (m_wvalid && m_wready) begin
                    mem[waddr] <= m_wdata;
                    waddr <= waddr + 10'd1;
                    if (m_wlast) begin
                        m_wready <= 1'b0;
                        m_bvalid <= 1'b1;
                        m_bid <= wid;
                        ws <= 2'd2;
                    end
                end
                default: if (m_bvalid && m_bready) begin
                    m_bvalid <= 1'b0;
                    ws <= 2'd0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            rs <= 1'b0;
            m_arready <= 1'b0;
            m_rvalid <= 1'b0;
            m_rlast <= 1'b0;
            m_rresp <= 2'd0;
            m_rid <= 1'b0;
        end else if (!rs) begin
            m_arready <= 1'b1;
            if (m_arvalid && m_arready) begin
                raddr <= m_araddr[11:2];
                rlen <= m_arlen;
                rcnt <= 8'd0;
                m_rid <= m_arid;
                m_arready <= 1'b0;
                m_rvalid <= 1'b1;
                m_rdata <= mem[m_araddr[11:2]];
                m_rlast <= (m_arlen == 8'd0);
                rs <= 1'b1;
            end
        end else if (m_rvalid && m_rready) begin
            if (m_rlast) begin
                m_rvalid <= 1'b0;
                m_rlast <= 1'b0;
                rs <= 1'b0;
            end else begin
                raddr <= raddr + 10'd1;
                m_rdata <= mem[raddr + 10'd1];
                m_rlast <= (rcnt + 8'd1 == rlen);
                rcnt <= rcnt + 8'd1;
            end
        end
    end

    // scoreboard
    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
        logic        last;
    } rexp_t;

    rexp_t      rq [2][$];
    logic [0:0] bq [2][$];
    logic [0:0] awq [$];
    logic [0:0] arq [$];
    int nchk = 0;
    int nfail = 0;
    int ovl_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        nchk++;
        nfail++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    always @(negedge clk) begin
        rexp_t re;
        logic [0:0] be;
        for (int p = 0; p < 2; p++) begin
            if (s_bvalid[p] && s_bready[p]) begin
                if (bq[p].size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL s%0d b unexpected: got bvalid 1 expected 0", p);
                end else begin
                    be = bq[p].pop_front();
                    chk($sformatf("s%0d bid", p), 32'(s_bid[p]), 32'(be));
                    chk($sformatf("s%0d bresp", p), 32'(s_bresp[p]), 32'd0);
                end
            end
            if (s_rvalid[p] && s_rready[p]) begin
                if (rq[p].size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL s%0d r unexpected: got rvalid 1 expected 0", p);
                end else begin
                    re = rq[p].pop_front();
                    chk($sformatf("s%0d rdata", p), s_rdata[p], re.data);
                    chk($sformatf("s%0d rlast", p), 32'(s_rlast[p]), 32'(re.last));
                    chk($sformatf("s%0d rid", p), 32'(s_rid[p]), 32'(re.id));
                end
            end
        end
        if (m_awvalid && m_awready && awq.size() > 0)
            chk("aw grant order", 32'(m_awid), 32'(awq.pop_front()));
        if (m_arvalid && m_arready && arq.size() > 0)
            chk("ar grant order", 32'(m_arid), 32'(arq.pop_front()));
        if (m_wvalid && m_rvalid) ovl_cnt++;
    end

    // stimulus
    task automatic aw_send(input int p, input logic [0:0] id, input logic [31:0] a,
                           input logic [7:0] len);
        int n = 0;
        s_awid[p] = id;
        s_awaddr[p] = a;
        s_awlen[p] = len;
        s_awvalid[p] = 1'b1;
        do begin @(negedge clk); n++; end while (!s_awready[p] && n < 300);
        if (!s_awready[p]) tmo($sformatf("s%0d aw", p));
        @(posedge clk); #1;
        s_awvalid[p] = 1'b0;
    endtask

    task automatic ar_send(input int p, input logic [0:0] id, input logic [31:0] a,
                           input logic [7:0] len);
        int n = 0;
        s_arid[p] = id;
        s_araddr[p] = a;
        s_arlen[p] = len;
        s_arvalid[p] = 1'b1;
        do begin @(negedge clk); n++; end while (!s_arready[p] && n < 300);
        if (!s_arready[p]) tmo($sformatf("s%0d ar", p));
        @(posedge clk); #1;
        s_arvalid[p] = 1'b0;
    endtask

    task automatic wr(input int p, input logic [0:0] id, input logic [31:0] a,
                      input logic [7:0] len, input logic [31:0] base, input int early);
        int n;
        bq[p].push_back(id);
        if (early > 0) begin
            s_wdata[p] = base;
            s_wlast[p] = (len == 8'd0);
            s_wvalid[p] = 1'b1;
            repeat (early) begin
                @(negedge clk);
                chk($sformatf("s%0d wready before aw", p), 32'(s_wready[p]), 32'd0);
                @(posedge clk); #1;
            end
        end
        aw_send(p, id, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            s_wdata[p] = base + 32'(i);
            s_wlast[p] = (i == int'(len));
            s_wvalid[p] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_wready[p] && n < 300);
            if (!s_wready[p]) tmo($sformatf("s%0d w", p));
            @(posedge clk); #1;
        end
        s_wvalid[p] = 1'b0;
        s_wlast[p] = 1'b0;
    endtask

    task automatic rd(input int p, input logic [0:0] id, input logic [31:0] a,
                      input logic [7:0] len, input logic [31:0] base);
        for (int i = 0; i <= int'(len); i++)
            rq[p].push_back(rexp_t'{id: id, data: base + 32'(i), last: (i == int'(len))});
        ar_send(p, id, a, len);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((rq[0].size() + rq[1].size() + bq[0].size() + bq[1].size()
                + awq.size() + arq.size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if ((rq[0].size() + rq[1].size() + bq[0].size() + bq[1].size()
             + awq.size() + arq.size()) != 0) begin
            tmo($sformatf("%s drain", nm));
            rq[0].delete(); rq[1].delete(); bq[0].delete(); bq[1].delete();
            awq.delete(); arq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, o0;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            s_awid[p] = '0; s_awaddr[p] = '0; s_awlen[p] = '0;
            s_awsize[p] = 3'd2; s_awburst[p] = 2'b01; s_awvalid[p] = 1'b0;
            s_wdata[p] = '0; s_wstrb[p] = 4'hF; s_wlast[p] = 1'b0; s_wvalid[p] = 1'b0;
            s_bready[p] = 1'b1;
            s_arid[p] = '0; s_araddr[p] = '0; s_arlen[p] = '0;
            s_arsize[p] = 3'd2; s_arburst[p] = 2'b01; s_arvalid[p] = 1'b0;
            s_rready[p] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("reset s%0d awready", p), 32'(s_awready[p]), 32'd0);
            chk($sformatf("reset s%0d wready", p), 32'(s_wready[p]), 32'd0);
            chk($sformatf("reset s%0d bvalid", p), 32'(s_bvalid[p]), 32'd0);
            chk($sformatf("reset s%0d arready", p), 32'(s_arready[p]), 32'd0);
            chk($sformatf("reset s%0d rvalid", p), 32'(s_rvalid[p]), 32'd0);
        end
        chk("reset m awvalid", 32'(m_awvalid), 32'd0);
        chk("reset m wvalid", 32'(m_wvalid), 32'd0);
        chk("reset m bready", 32'(m_bready), 32'd0);
        chk("reset m arvalid", 32'(m_arvalid), 32'd0);
        chk("reset m rready", 32'(m_rready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T1: s0 write 1..4 at 0x10, read back
        wr(0, 1'b0, 32'h10, 8'd3, 32'd1, 0);
        wait_idle("T1 write");
        rd(0, 1'b0, 32'h10, 8'd3, 32'd1);
        wait_idle("T1 read");

        // T2: simultaneous AW after reset, s1 first
        do_reset();
        awq.push_back(1'b1);
        awq.push_back(1'b0);
        fork
            wr(0, 1'b0, 32'h20, 8'd0, 32'h55, 0);
            wr(1, 1'b1, 32'h30, 8'd0, 32'h66, 0);
        join
        wait_idle("T2 write");
        rd(0, 1'b0, 32'h20, 8'd0, 32'h55);
        rd(1, 1'b1, 32'h30, 8'd0, 32'h66);
        wait_idle("T2 read");

        // T3: continuous single-beat reads alternate 1,0,1,0...
        do_reset();
        for (int i = 0; i < 8; i++) arq.push_back((i % 2 == 0) ? 1'b1 : 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++)
                    rd(0, 1'b0, 32'h100 + 32'(4 * i), 8'd0, 32'hA000_0040 + 32'(i));
            end
            begin
                for (int j = 0; j < 4; j++)
                    rd(1, 1'b1, 32'h200 + 32'(4 * j), 8'd0, 32'hA000_0080 + 32'(j));
            end
        join
        wait_idle("T3");

        // T4: s0 write len 7 overlapping s1 read len 7
        o0 = ovl_cnt;
        fork
            wr(0, 1'b0, 32'h300, 8'd7, 32'h700, 0);
            rd(1, 1'b1, 32'h400, 8'd7, 32'hA000_0100);
        join
        wait_idle("T4");
        chk("T4 overlap", 32'(ovl_cnt > o0), 32'd1);
        rd(0, 1'b0, 32'h300, 8'd7, 32'h700);
        wait_idle("T4 readback");

        // T5: s1 W presented 5 cycles before AW
        wr(1, 1'b1, 32'h500, 8'd1, 32'h5A0, 5);
        wait_idle("T5 write");
        rd(1, 1'b1, 32'h500, 8'd1, 32'h5A0);
        wait_idle("T5 read");

        // T6: reset during beat 2 of an s0 read
        do_reset();
        rq[0].push_back(rexp_t'{id: 1'b0, data: 32'hA000_0180, last: 1'b0});
        rq[0].push_back(rexp_t'{id: 1'b0, data: 32'hA000_0181, last: 1'b0});
        ar_send(0, 1'b0, 32'h600, 8'd3);
        n = 0;
        k = 0;
        while (k < 2 && n < 300) begin
            @(negedge clk);
            n++;
            if (s_rvalid[0]) k++;
        end
        if (k < 2) tmo("T6 beat 2");
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("T6 s0 rvalid after reset", 32'(s_rvalid[0]), 32'd0);
        chk("T6 m rready after reset", 32'(m_rready), 32'd0);
        chk("T6 m arvalid after reset", 32'(m_arvalid), 32'd0);
        @(posedge clk); #1;
        rd(0, 1'b0, 32'h600, 8'd0, 32'hA000_0180);
        wait_idle("T6");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
